// File: rtl/branch_predictor_if.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predictor_if
//  Description : Fetch/branch-stage bundle between the pipeline and the
//                dynamic branch predictor.
//                  master  - pipeline side: drives PCF and the B-stage
//                            training inputs, receives the prediction
//                  slave   - predictor side
//                Signals:
//                  PCF          fetch PC (word aligned)
//                  PredTakenF   predict taken for PCF
//                  PredTargetF  predicted next PC
//                  PhtIdxF      PHT index used for PCF, carried to B
//                  UpdateB      valid, unflushed branch/jump resolving in B
//                  BranchB      resolving instruction is a conditional branch
//                  JumpB        resolving instruction is jal/jalr
//                  TakenB       resolved direction (1 for jumps)
//                  PCB          PC of the resolving instruction
//                  TargetB      resolved target
//                  PhtIdxB      PhtIdxF captured at fetch of that instruction
//  Revision    : 1.0 - initial release
// ============================================================================
interface branch_predictor_if #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16
);
  localparam int IDX = $clog2(ENTRIES);

  logic [XLEN-1:0] PCF;
  logic            PredTakenF;
  logic [XLEN-1:0] PredTargetF;
  logic [IDX-1:0]  PhtIdxF;

  logic            UpdateB;
  logic            BranchB;
  logic            JumpB;
  logic            TakenB;
  logic [XLEN-1:0] PCB;
  logic [XLEN-1:0] TargetB;
  logic [IDX-1:0]  PhtIdxB;

  modport master (
    output PCF,
    input  PredTakenF, PredTargetF, PhtIdxF,
    output UpdateB, BranchB, JumpB, TakenB, PCB, TargetB, PhtIdxB
  );

  modport slave (
    input  PCF,
    output PredTakenF, PredTargetF, PhtIdxF,
    input  UpdateB, BranchB, JumpB, TakenB, PCB, TargetB, PhtIdxB
  );
endinterface
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predictor
//  Description : Fetch-stage dynamic branch predictor. A direct-mapped BTB
//                (valid/tag/target) and a PHT of 2-bit saturating counters
//                are looked up combinationally with the fetch PC; both are
//                trained by control-flow instructions resolving in B.
//                Configuration macro BP_GSHARE_EN: when defined, the PHT is
//                indexed by PC bits XOR a global history register (gshare);
//                otherwise the PHT is indexed by PC bits alone (bimodal) and
//                no history flops exist.
//  Ports       : clk   - clock
//                reset - synchronous, active-high
//                bp    - branch_predictor_if.slave (lookup + training)
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16
) (
  input  logic               clk,
  input  logic               reset,
  branch_predictor_if.slave  bp
);

  localparam int IDX  = $clog2(ENTRIES);
  localparam int TAGW = XLEN - IDX - 2;

  // --------------------------------------------------------------------------
  // Storage
  // --------------------------------------------------------------------------
  logic [ENTRIES-1:0] r_btb_valid;
  logic [TAGW-1:0]    r_btb_tag    [ENTRIES];
  logic [XLEN-1:0]    r_btb_target [ENTRIES];
  logic [1:0]         r_pht        [ENTRIES];

  // --------------------------------------------------------------------------
  // Lookup (combinational from PCF and current state, no bypass)
  // --------------------------------------------------------------------------
  logic [IDX-1:0]  w_bidx;
  logic [TAGW-1:0] w_tag;
  logic            w_hit;
  logic [IDX-1:0]  w_pht_idx;
  logic            w_pred_taken;

  assign w_bidx = bp.PCF[IDX+1:2];
  assign w_tag  = bp.PCF[XLEN-1:IDX+2];
  assign w_hit  = r_btb_valid[w_bidx] & (r_btb_tag[w_bidx] == w_tag);

`ifdef BP_GSHARE_EN
  logic [IDX-1:0] r_ghr;
  assign w_pht_idx = w_bidx ^ r_ghr;
`else
  assign w_pht_idx = w_bidx;
`endif

  assign w_pred_taken   = w_hit & r_pht[w_pht_idx][1];
  assign bp.PredTakenF  = w_pred_taken;
  assign bp.PredTargetF = w_pred_taken ? r_btb_target[w_bidx]
                                       : bp.PCF + XLEN'(4);
  assign bp.PhtIdxF     = w_pht_idx;

  // --------------------------------------------------------------------------
  // Training
  // --------------------------------------------------------------------------
  logic [IDX-1:0]  w_ubidx;
  logic [TAGW-1:0] w_utag;
  logic [1:0]      w_pht_cur;
  logic [1:0]      w_pht_next;

  assign w_ubidx   = bp.PCB[IDX+1:2];
  assign w_utag    = bp.PCB[XLEN-1:IDX+2];
  assign w_pht_cur = r_pht[bp.PhtIdxB];

  // Saturating step: never wraps 11->00 or 00->11.
  always_comb begin
    w_pht_next = w_pht_cur;
    if (bp.TakenB) begin
      if (w_pht_cur != 2'b11) w_pht_next = w_pht_cur + 2'b01;
    end else begin
      if (w_pht_cur != 2'b00) w_pht_next = w_pht_cur - 2'b01;
    end
  end

  // Valid bits and counters: reset-initialised state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_btb_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) r_pht[i] <= 2'b01;
    end else if (bp.UpdateB) begin
      // Any taken resolution (re)writes the entry: a hit refreshes the
      // target, a miss allocates over whatever was there.
      if (bp.TakenB) r_btb_valid[w_ubidx] <= 1'b1;
      if (bp.BranchB)    r_pht[bp.PhtIdxB] <= w_pht_next;
      else if (bp.JumpB) r_pht[bp.PhtIdxB] <= 2'b11;
    end
  end

  // Tags and targets carry no reset value; they are qualified by valid.
  always_ff @(posedge clk) begin
    if (!reset && bp.UpdateB && bp.TakenB) begin
      r_btb_tag[w_ubidx]    <= w_utag;
      r_btb_target[w_ubidx] <= bp.TargetB;
    end
  end

`ifdef BP_GSHARE_EN
  // History is updated non-speculatively from B; jumps do not shift it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ghr <= '0;
    end else if (bp.UpdateB && bp.BranchB) begin
      r_ghr <= {r_ghr[IDX-2:0], bp.TakenB};
    end
  end
`endif

  // Low PC bits are always zero for word-aligned fetch.
  logic w_unused;
  assign w_unused = &{1'b0, bp.PCF[1:0], bp.PCB[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_predictor
//  Description : Scoreboard bench for branch_predictor. Stimulus pushes the
//                hand-computed prediction for each lookup; a monitor pops and
//                compares on the falling edge. Builds against the bimodal
//                configuration by default, gshare when BP_GSHARE_EN is set.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predictor;

  localparam int XLEN    = 32;
  localparam int ENTRIES = 16;
  localparam int IDX     = 4;

  logic clk;
  logic reset;

  branch_predictor_if #(.XLEN(XLEN), .ENTRIES(ENTRIES)) bp_if ();

  branch_predictor #(.XLEN(XLEN), .ENTRIES(ENTRIES)) dut (
    .clk   (clk),
    .reset (reset),
    .bp    (bp_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string           name;
    logic            taken;
    logic [XLEN-1:0] tgt;
    logic [IDX-1:0]  idx;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // --------------------------------------------------------------------------
  // Monitor / scoreboard
  // --------------------------------------------------------------------------
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_checks++;
      if (bp_if.PredTakenF !== e.taken || bp_if.PredTargetF !== e.tgt ||
          bp_if.PhtIdxF !== e.idx) begin
        n_errors++;
        $display("FAIL %s: got taken=%0b target=0x%08h idx=0x%0h, want taken=%0b target=0x%08h idx=0x%0h",
                 e.name, bp_if.PredTakenF, bp_if.PredTargetF, bp_if.PhtIdxF,
                 e.taken, e.tgt, e.idx);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
    bp_if.UpdateB = 1'b0;
    bp_if.BranchB = 1'b0;
    bp_if.JumpB   = 1'b0;
    bp_if.TakenB  = 1'b0;
  endtask

  task automatic expect_now(input string name, input logic t,
                            input logic [XLEN-1:0] tg, input logic [IDX-1:0] ix);
    exp_t e;
    e.name = name; e.taken = t; e.tgt = tg; e.idx = ix;
    q.push_back(e);
  endtask

  task automatic set_upd(input logic br, input logic jp, input logic tk,
                         input logic [XLEN-1:0] pcb, input logic [XLEN-1:0] tgt,
                         input logic [IDX-1:0] ix);
    bp_if.UpdateB = 1'b1;
    bp_if.BranchB = br;
    bp_if.JumpB   = jp;
    bp_if.TakenB  = tk;
    bp_if.PCB     = pcb;
    bp_if.TargetB = tgt;
    bp_if.PhtIdxB = ix;
  endtask

  task automatic upd(input logic br, input logic jp, input logic tk,
                     input logic [XLEN-1:0] pcb, input logic [XLEN-1:0] tgt,
                     input logic [IDX-1:0] ix);
    set_upd(br, jp, tk, pcb, tgt, ix);
    tick();
  endtask

  task automatic look(input string name, input logic [XLEN-1:0] pc, input logic t,
                      input logic [XLEN-1:0] tg, input logic [IDX-1:0] ix);
    bp_if.PCF = pc;
    expect_now(name, t, tg, ix);
    tick();
  endtask

  // --------------------------------------------------------------------------
  // Watchdog
  // --------------------------------------------------------------------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // --------------------------------------------------------------------------
  // Directed sequence
  // --------------------------------------------------------------------------
  initial begin
    reset         = 1'b1;
    bp_if.PCF     = '0;
    bp_if.UpdateB = 1'b0;
    bp_if.BranchB = 1'b0;
    bp_if.JumpB   = 1'b0;
    bp_if.TakenB  = 1'b0;
    bp_if.PCB     = '0;
    bp_if.TargetB = '0;
    bp_if.PhtIdxB = '0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state: no hits anywhere, fall-through with wrap.
    look("rst_0x100",  32'h0000_0100, 1'b0, 32'h0000_0104, 4'h0);
    look("rst_0x13c",  32'h0000_013C, 1'b0, 32'h0000_0140, 4'hF);
    look("rst_wrap",   32'hFFFF_FFFC, 1'b0, 32'h0000_0000, 4'hF);

`ifdef BP_GSHARE_EN
    // Taken branch (GHR=0001), then not-taken branch (GHR=0010).
    upd(1'b1, 1'b0, 1'b1, 32'h0000_0040, 32'h0000_0080, 4'h0); // pht[0]=10
    upd(1'b1, 1'b0, 1'b0, 32'h0000_0044, 32'h0000_0000, 4'h1); // pht[1]=00
    look("gs_idx_0x100", 32'h0000_0100, 1'b0, 32'h0000_0104, 4'h2);
    // Jump at 0x108: pht[2]=11, BTB[2]=0x300, GHR unchanged.
    upd(1'b0, 1'b1, 1'b1, 32'h0000_0108, 32'h0000_0300, 4'h2);
    look("gs_jmp_noshift", 32'h0000_0108, 1'b1, 32'h0000_0300, 4'h0);
    look("gs_hit_0x40",    32'h0000_0040, 1'b1, 32'h0000_0080, 4'h2);
    // Same-cycle history update: lookup sees old GHR, next cycle the new one.
    bp_if.PCF = 32'h0000_0040;
    set_upd(1'b1, 1'b0, 1'b1, 32'h0000_007C, 32'h0000_0700, 4'h5);
    expect_now("gs_old_ghr", 1'b1, 32'h0000_0080, 4'h2);
    tick();
    look("gs_new_ghr",   32'h0000_0040, 1'b1, 32'h0000_0080, 4'h5);
    look("gs_new_0x7c",  32'h0000_007C, 1'b0, 32'h0000_0080, 4'hA);
    // Reset clears the history.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    look("gs_rst_idx",   32'h0000_0108, 1'b0, 32'h0000_010C, 4'h2);
`else
    // Single taken branch: counter 01->10, BTB allocated.
    upd(1'b1, 1'b0, 1'b1, 32'h0000_0100, 32'h0000_0200, 4'h0);
    look("bm_first_taken", 32'h0000_0100, 1'b1, 32'h0000_0200, 4'h0);

    // Saturation up and down.
    for (int i = 0; i < 4; i++) upd(1'b1, 1'b0, 1'b1, 32'h0000_0100, 32'h0000_0200, 4'h0);
    look("sat_11",        32'h0000_0100, 1'b1, 32'h0000_0200, 4'h0);
    upd(1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'h0000_0DEC, 4'h0);
    look("sat_10",        32'h0000_0100, 1'b1, 32'h0000_0200, 4'h0);
    upd(1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'h0000_0DEC, 4'h0);
    upd(1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'h0000_0DEC, 4'h0);
    look("sat_00",        32'h0000_0100, 1'b0, 32'h0000_0104, 4'h0);

    // UpdateB low: other B inputs must be ignored.
    bp_if.BranchB = 1'b1; bp_if.TakenB = 1'b1; bp_if.JumpB = 1'b0;
    bp_if.PCB = 32'h0000_0100; bp_if.TargetB = 32'h0000_0999; bp_if.PhtIdxB = 4'h0;
    tick();
    bp_if.BranchB = 1'b1; bp_if.TakenB = 1'b1;
    tick();

    // Raise pht[0] via a different PC; BTB entry 0 must still be valid.
    upd(1'b1, 1'b0, 1'b1, 32'h0000_013C, 32'h0000_0500, 4'h0);
    upd(1'b1, 1'b0, 1'b1, 32'h0000_013C, 32'h0000_0500, 4'h0);
    look("btb_kept_valid", 32'h0000_0100, 1'b1, 32'h0000_0200, 4'h0);
    look("pht15_weak_nt",  32'h0000_013C, 1'b0, 32'h0000_0140, 4'hF);

    // Aliasing: 0x140 shares index 0 with a different tag.
    look("alias_miss",     32'h0000_0140, 1'b0, 32'h0000_0144, 4'h0);
    upd(1'b0, 1'b1, 1'b1, 32'h0000_0140, 32'h0000_0300, 4'h0);
    look("alias_replace",  32'h0000_0140, 1'b1, 32'h0000_0300, 4'h0);
    look("alias_old_miss", 32'h0000_0100, 1'b0, 32'h0000_0104, 4'h0);

    // Same-cycle update and lookup: old value now, new value next cycle.
    bp_if.PCF = 32'h0000_0100;
    set_upd(1'b1, 1'b0, 1'b1, 32'h0000_0100, 32'h0000_0200, 4'h0);
    expect_now("coll_old", 1'b0, 32'h0000_0104, 4'h0);
    tick();
    look("coll_new",       32'h0000_0100, 1'b1, 32'h0000_0200, 4'h0);

    // Reset wins over a simultaneous update.
    reset = 1'b1;
    set_upd(1'b1, 1'b0, 1'b1, 32'h0000_0100, 32'h0000_0200, 4'h0);
    tick();
    reset = 1'b0;
    look("rst_drops_upd",  32'h0000_0100, 1'b0, 32'h0000_0104, 4'h0);

    // Counters return to 01 on reset (pht[0] was 11 before).
    upd(1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'h0000_0000, 4'h0); // 00
    upd(1'b1, 1'b0, 1'b1, 32'h0000_0100, 32'h0000_0200, 4'h0); // 01
    look("rst_pht_01",     32'h0000_0100, 1'b0, 32'h0000_0104, 4'h0);
    upd(1'b1, 1'b0, 1'b1, 32'h0000_0100, 32'h0000_0200, 4'h0); // 10
    look("rst_pht_10",     32'h0000_0100, 1'b1, 32'h0000_0200, 4'h0);
`endif

    tick();
    tick();
    n_checks++;
    if (q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
